corr_search_ctrl: RTL and testbench
===================================

# corr_search_ctrl

Sequencer for the correlation score unit. On a start pulse it raster-sweeps candidate start positions over a rectangular window with a programmable step. For each position it hands one (X, Y) start coordinate to the correlator, waits for that position's score, and tracks the maximum score and its coordinates. It sits between the tracking/top-level control and the correlation datapath, and reports the best-match location plus an error flag for correlator timeouts.

## Interface
- COORD_W, 13, coordinate width (matches correlator/SRAM coordinate ports)
- SCORE_W, 24, correlator score width
- TIMEOUT, 65535, max cycles to wait for iCorrDone per position
- iCLK  in  1  system clock (50 MHz)
- iRST  in  1  reset; one clock, reset synchronous and active-high
- iStart  in  1  sweep request pulse; honoured only in IDLE
- iXmin, iYmin, iXmax, iYmax  in  COORD_W  inclusive sweep window, sampled on accepted iStart
- iStep  in  4  sweep step in both axes, sampled on accepted iStart; 0 treated as 1
- oCorrStart  out  1  one-cycle pulse to correlator
- oXstart, oYstart  out  COORD_W  candidate position; stable from the oCorrStart cycle until the score is captured
- iCorrDone  in  1  correlator score-valid pulse
- iCorrScore  in  SCORE_W  score, valid when iCorrDone=1
- oBusy  out  1  high in every state except IDLE
- oDone  out  1  one-cycle pulse at sweep end (normal or error)
- oError  out  1  set on timeout or invalid window; cleared on the next accepted iStart
- oBestX, oBestY  out  COORD_W  coordinates of best score
- oBestScore  out  SCORE_W  best score
- oCount  out  16  positions evaluated in the current/last sweep

## Operation
- States: IDLE, ISSUE, WAIT, UPDATE, DONE.
- IDLE, with iStart=1:
  - Latch the window and step.
  - If iXmin>iXmax or iYmin>iYmax: set oError=1 and oCount=0, go to DONE.
  - Otherwise: set X=iXmin, Y=iYmin; clear oBestScore, oCount, oError and the internal best-valid flag; set oBestX/oBestY=iXmin/iYmin; go to ISSUE.
- ISSUE: drive oCorrStart=1 for exactly this cycle, clear the watchdog, go to WAIT.
- WAIT:
  - iCorrDone=1: capture iCorrScore, go to UPDATE.
  - Watchdog reaches TIMEOUT: set oError=1, go to DONE. Best/count keep the values from positions already completed.
  - iCorrDone and timeout in the same cycle: iCorrDone wins.
- UPDATE:
  - oCount+1.
  - If the best-valid flag is 0, or score > oBestScore (strictly greater): load best score and X/Y, set the flag. Ties keep the earlier position in raster order.
  - Next position, computed at COORD_W+1 bits so there is no wrap at 8191:
    - X+step ≤ Xmax: X+=step, go to ISSUE.
    - Else if Y+step ≤ Ymax: X=Xmin, Y+=step, go to ISSUE.
    - Else go to DONE.
- DONE: oDone=1 for one cycle, go to IDLE. Results hold until the next accepted iStart.
- Ignored inputs: iStart outside IDLE; iCorrDone outside WAIT.
- oCount saturates at 16'hFFFF.

## Timing
- All outputs are registered. Reset value of every output is 0: oCorrStart, oBusy, oDone, oError, oBestX/Y, oBestScore, oCount, oXstart/Y. State resets to IDLE.
- iStart accepted at cycle T: oBusy=1 and state ISSUE at T+1; oCorrStart=1 at T+1.
- Per position: 1 ISSUE + (correlator latency L, counted from oCorrStart to iCorrDone) + 1 UPDATE cycle, i.e. L+2 cycles.
- iCorrDone at cycle C: best/count update visible at C+2. The next oCorrStart is at C+2, or DONE at C+2 with oDone=1 at C+2 and oBusy=0 at C+3.
- Invalid window: oDone and oError both high at T+1.
- Reset mid-sweep: IDLE next cycle, all outputs 0, no further oCorrStart. A correlator still running is ignored.

## Structure
- Shared params header/package holds: COORD_W, SCORE_W, SEARCH_H_RES, SEARCH_V_RES, the default TIMEOUT, and the state encoding constants.
- One natural sub-module: corr_best_tracker. It holds the best-valid flag, compare-and-load of score/X/Y, and the saturating count; clear and update strobes come from the FSM.
- The FSM, coordinate stepper and watchdog live in corr_search_ctrl.

## Test plan
- Window (10,20)-(12,21), step 1, scores 5,9,9,3,2,7: 6 oCorrStart pulses in raster order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21). Result: oBestScore=9, oBest=(11,20), oCount=6, one oDone, oError=0.
- Step 0 vs step 1 on window (0,0)-(3,0): identical 4-position sweep. Step 3 on (0,0)-(7,7): positions X,Y ∈ {0,3,6}, oCount=9.
- Window Xmin=8191=Xmax, Ymin=Ymax=0: exactly one position, no wrap, oCount=1.
- iXmin=5, iXmax=4: oDone and oError at T+1, oCount=0, no oCorrStart.
- TIMEOUT=16, correlator silent on the 2nd position: oError=1, oCount=1, oDone 17 cycles after the 2nd oCorrStart. iCorrDone arriving later is ignored.
- iRST asserted mid-WAIT, then iStart during the busy period of a new sweep, plus a stray iCorrDone in IDLE: all outputs 0 after reset. The mid-sweep iStart is ignored. The stray iCorrDone changes nothing.

Source files
------------

// File: rtl/corr_search_ctrl_pkg.sv
// corr_search_ctrl_pkg: shared widths, sweep defaults and sequencer state encoding
package corr_search_ctrl_pkg;
    localparam int COORD_W = 13;
    localparam int SCORE_W = 24;
    localparam int SEARCH_H_RES = 640;
    localparam int SEARCH_V_RES = 480;
    localparam int TIMEOUT = 65535;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_t;
endpackage

// File: rtl/corr_best_tracker.sv
// corr_best_tracker: best-score compare-and-load plus saturating position count
module corr_best_tracker #(
    parameter int COORD_W = 13,
    parameter int SCORE_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_cnt,
    input  logic               init,
    input  logic               upd,
    input  logic [COORD_W-1:0] init_x,
    input  logic [COORD_W-1:0] init_y,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [SCORE_W-1:0] score,
    output logic [COORD_W-1:0] best_x,
    output logic [COORD_W-1:0] best_y,
    output logic [SCORE_W-1:0] best_score,
    output logic [15:0]        count
);
    logic valid;
    logic take;
    // strict compare: ties keep the earlier raster position
    always_comb take = upd && (!valid || score > best_score);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            best_x <= '0;
            best_y <= '0;
            best_score <= '0;
            count <= '0;
        end else begin
            if (clr_cnt) count <= '0;
            else if (upd && count != 16'hFFFF) count <= count + 16'd1;
            if (init) begin
                valid <= 1'b0;
                best_x <= init_x;
                best_y <= init_y;
                best_score <= '0;
            end else if (take) begin
                valid <= 1'b1;
                best_x <= x;
                best_y <= y;
                best_score <= score;
            end
        end
    end
endmodule

// File: rtl/corr_search_ctrl.sv
// corr_search_ctrl: raster-sweep sequencer driving the correlator and tracking the best match
module corr_search_ctrl #(
    parameter int COORD_W = corr_search_ctrl_pkg::COORD_W,
    parameter int SCORE_W = corr_search_ctrl_pkg::SCORE_W,
    parameter int TIMEOUT = corr_search_ctrl_pkg::TIMEOUT
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    input  logic [COORD_W-1:0] iXmin,
    input  logic [COORD_W-1:0] iYmin,
    input  logic [COORD_W-1:0] iXmax,
    input  logic [COORD_W-1:0] iYmax,
    input  logic [3:0]         iStep,
    output logic               oCorrStart,
    output logic [COORD_W-1:0] oXstart,
    output logic [COORD_W-1:0] oYstart,
    input  logic               iCorrDone,
    input  logic [SCORE_W-1:0] iCorrScore,
    output logic               oBusy,
    output logic               oDone,
    output logic               oError,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY,
    output logic [SCORE_W-1:0] oBestScore,
    output logic [15:0]        oCount
);
    import corr_search_ctrl_pkg::*;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    state_t state, next_state;
    logic [COORD_W-1:0] xmin, xmax, ymax;
    logic [3:0] step;
    logic [WD_W-1:0] wd;
    logic [SCORE_W-1:0] score_q;
    logic [COORD_W:0] xn, yn;
    logic accept, bad, x_ok, y_ok, timeout, init, upd, set_err;

    always_ff @(posedge iCLK) begin
        if (iRST) state <= S_IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (iStart) next_state = bad ? S_DONE : S_ISSUE;
            S_ISSUE:  next_state = S_WAIT;
            S_WAIT:   next_state = iCorrDone ? S_UPDATE : (timeout ? S_DONE : S_WAIT);
            S_UPDATE: next_state = (x_ok || y_ok) ? S_ISSUE : S_DONE;
            default:  next_state = S_IDLE;
        endcase
    end

    // next-position sums carry an extra bit so a window ending at the top coordinate cannot wrap
    always_comb begin
        accept = state == S_IDLE && iStart;
        bad = iXmin > iXmax || iYmin > iYmax;
        xn = (COORD_W+1)'(oXstart) + (COORD_W+1)'(step);
        yn = (COORD_W+1)'(oYstart) + (COORD_W+1)'(step);
        x_ok = xn <= (COORD_W+1)'(xmax);
        y_ok = yn <= (COORD_W+1)'(ymax);
        timeout = wd == WD_W'(TIMEOUT - 1);
        init = accept && !bad;
        upd = state == S_UPDATE;
        set_err = (accept && bad) || (state == S_WAIT && !iCorrDone && timeout);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oCorrStart <= 1'b0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
            oError <= 1'b0;
            oXstart <= '0;
            oYstart <= '0;
            xmin <= '0;
            xmax <= '0;
            ymax <= '0;
            step <= 4'd1;
            wd <= '0;
            score_q <= '0;
        end else begin
            oCorrStart <= next_state == S_ISSUE;
            oBusy <= next_state != S_IDLE;
            oDone <= next_state == S_DONE;
            oError <= accept ? bad : (oError || set_err);
            wd <= state == S_WAIT ? wd + WD_W'(1) : '0;
            if (state == S_WAIT && iCorrDone) score_q <= iCorrScore;
            if (accept) begin
                xmin <= iXmin;
                xmax <= iXmax;
                ymax <= iYmax;
                step <= iStep == 4'd0 ? 4'd1 : iStep;
            end
            if (init) begin
                oXstart <= iXmin;
                oYstart <= iYmin;
            end else if (upd && x_ok) begin
                oXstart <= xn[COORD_W-1:0];
            end else if (upd && y_ok) begin
                oXstart <= xmin;
                oYstart <= yn[COORD_W-1:0];
            end
        end
    end

    corr_best_tracker #(.COORD_W(COORD_W), .SCORE_W(SCORE_W)) u_tracker (
        .clk(iCLK),
        .rst(iRST),
        .clr_cnt(accept),
        .init(init),
        .upd(upd),
        .init_x(iXmin),
        .init_y(iYmin),
        .x(oXstart),
        .y(oYstart),
        .score(score_q),
        .best_x(oBestX),
        .best_y(oBestY),
        .best_score(oBestScore),
        .count(oCount)
    );
endmodule

// File: tb/tb_corr_search_ctrl.sv
// tb_corr_search_ctrl: randomized sweeps checked against a raster/argmax model of the search
module tb_corr_search_ctrl;
    logic iCLK = 1'b0, iRST = 1'b1, iStart = 1'b0, iCorrDone = 1'b0;
    logic [12:0] iXmin = '0, iYmin = '0, iXmax = '0, iYmax = '0;
    logic [3:0] iStep = '0;
    logic [23:0] iCorrScore = '0;
    logic oCorrStart, oBusy, oDone, oError;
    logic [12:0] oXstart, oYstart, oBestX, oBestY;
    logic [23:0] oBestScore;
    logic [15:0] oCount;
    int checks = 0, errors = 0;
    int obs_x[$], obs_y[$], st_cyc[$], cd_cyc[$], used[$], scores[$], exp_x[$], exp_y[$];
    int ndone, done_cyc, busy_first, busy_after;

    corr_search_ctrl #(.COORD_W(13), .SCORE_W(24), .TIMEOUT(16)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iXmin(iXmin), .iYmin(iYmin),
        .iXmax(iXmax), .iYmax(iYmax), .iStep(iStep), .oCorrStart(oCorrStart),
        .oXstart(oXstart), .oYstart(oYstart), .iCorrDone(iCorrDone), .iCorrScore(iCorrScore),
        .oBusy(oBusy), .oDone(oDone), .oError(oError), .oBestX(oBestX), .oBestY(oBestY),
        .oBestScore(oBestScore), .oCount(oCount)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    // Raster enumeration of the window, step 0 meaning 1
    function automatic void model_positions(input int x0, y0, x1, y1, st);
        int s = st == 0 ? 1 : st;
        exp_x.delete();
        exp_y.delete();
        if (x0 > x1 || y0 > y1) return;
        for (int y = y0; y <= y1; y += s)
            for (int x = x0; x <= x1; x += s) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endfunction

    // First index holding the maximum of the scores actually delivered
    function automatic int best_idx();
        int b = 0;
        for (int i = 1; i < used.size(); i++) if (used[i] > used[b]) b = i;
        return b;
    endfunction

    function automatic bit pos_match();
        if (obs_x.size() != exp_x.size()) return 0;
        for (int i = 0; i < exp_x.size(); i++)
            if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i]) return 0;
        return 1;
    endfunction

    function automatic bit timing_ok();
        if (st_cyc.size() > 0 && st_cyc[0] != 0) return 0;
        for (int i = 1; i < st_cyc.size(); i++) if (st_cyc[i] != cd_cyc[i-1] + 2) return 0;
        if (cd_cyc.size() == st_cyc.size() && cd_cyc.size() > 0)
            return done_cyc == cd_cyc[cd_cyc.size()-1] + 2;
        return 1;
    endfunction

    // Drives one sweep, acting as a correlator with random latency; silent = 1-based position left unanswered
    task automatic run_sweep(input int x0, y0, x1, y1, st, silent, poke);
        int lat = 0, npos = 0, s;
        bit pending = 0;
        obs_x.delete(); obs_y.delete(); st_cyc.delete(); cd_cyc.delete(); used.delete();
        ndone = 0; done_cyc = -1; busy_after = 1;
        iXmin = 13'(x0); iYmin = 13'(y0); iXmax = 13'(x1); iYmax = 13'(y1); iStep = 4'(st);
        iStart = 1'b1;
        tick;
        busy_first = int'(oBusy);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            iStart = 1'b0;
            iCorrDone = 1'b0;
            if (poke != 0 && cyc == 2) begin
                iStart = 1'b1; iXmin = '0; iYmin = '0; iXmax = 13'd100; iYmax = 13'd100; iStep = 4'd1;
            end
            if (oCorrStart) begin
                obs_x.push_back(int'(oXstart));
                obs_y.push_back(int'(oYstart));
                st_cyc.push_back(cyc);
                npos++;
                pending = npos != silent;
                lat = $urandom_range(1, 8);
            end else if (pending) begin
                lat--;
                if (lat == 0) begin
                    pending = 0;
                    s = scores.size() > 0 ? scores.pop_front() : int'($urandom_range(0, 15));
                    used.push_back(s);
                    cd_cyc.push_back(cyc);
                    iCorrDone = 1'b1;
                    iCorrScore = 24'(s);
                end
            end
            if (oDone) begin
                ndone++;
                done_cyc = cyc;
                tick;
                busy_after = int'(oBusy);
                ndone += int'(oDone);
                break;
            end
            tick;
        end
        iStart = 1'b0;
        iCorrDone = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({oCorrStart, oBusy, oDone, oError, oXstart, oYstart, oBestX, oBestY, oBestScore, oCount} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b cnt=%0d best=%0d, want all zero",
                     oBusy, oDone, oError, oCount, oBestScore);
        end
    endtask

    task automatic test_basic_window;
        int bi;
        scores = '{5, 9, 9, 3, 2, 7};
        run_sweep(10, 20, 12, 21, 1, 0, 0);
        model_positions(10, 20, 12, 21, 1);
        bi = best_idx();
        checks++;
        if (!pos_match()) begin errors++; $display("FAIL basic_positions: got %0d starts, want %0d in raster order", obs_x.size(), exp_x.size()); end
        checks++;
        if (oBestScore !== 24'd9 || 9 != used[bi]) begin errors++; $display("FAIL basic_best_score: got %0d, want 9", oBestScore); end
        checks++;
        if (oBestX !== 13'd11 || oBestY !== 13'd20) begin errors++; $display("FAIL basic_best_xy: got (%0d,%0d), want (11,20)", oBestX, oBestY); end
        checks++;
        if (oCount !== 16'd6) begin errors++; $display("FAIL basic_count: got %0d, want 6", oCount); end
        checks++;
        if (ndone != 1 || oError !== 1'b0) begin errors++; $display("FAIL basic_done_err: got done=%0d err=%0b, want 1/0", ndone, oError); end
        checks++;
        if (busy_first != 1 || busy_after != 0) begin errors++; $display("FAIL basic_busy: got %0d/%0d, want 1/0", busy_first, busy_after); end
        checks++;
        if (!timing_ok()) begin errors++; $display("FAIL basic_timing: first start cyc %0d done cyc %0d, want 0 and score+2", st_cyc[0], done_cyc); end
    endtask

    task automatic test_step;
        int ref_x[$];
        run_sweep(0, 0, 3, 0, 0, 0, 0);
        ref_x = obs_x;
        model_positions(0, 0, 3, 0, 0);
        checks++;
        if (!pos_match() || oCount !== 16'd4) begin errors++; $display("FAIL step0_sweep: got %0d starts cnt %0d, want 4", obs_x.size(), oCount); end
        run_sweep(0, 0, 3, 0, 1, 0, 0);
        checks++;
        if (obs_x != ref_x || oCount !== 16'd4) begin errors++; $display("FAIL step1_vs_step0: got %0d starts cnt %0d, want 4 identical", obs_x.size(), oCount); end
        run_sweep(0, 0, 7, 7, 3, 0, 0);
        model_positions(0, 0, 7, 7, 3);
        checks++;
        if (!pos_match() || oCount !== 16'd9) begin errors++; $display("FAIL step3_grid: got %0d starts cnt %0d, want 9", obs_x.size(), oCount); end
        checks++;
        if (oBestScore !== 24'(used[best_idx()]) || oBestX !== 13'(exp_x[best_idx()]) || oBestY !== 13'(exp_y[best_idx()])) begin
            errors++; $display("FAIL step3_best: got %0d@(%0d,%0d), want %0d", oBestScore, oBestX, oBestY, used[best_idx()]);
        end
    endtask

    task automatic test_edge_coord;
        scores = '{0};
        run_sweep(8191, 0, 8191, 0, 1, 0, 0);
        checks++;
        if (obs_x.size() != 1 || oCount !== 16'd1 || ndone != 1) begin errors++; $display("FAIL edge_single: got %0d starts cnt %0d done %0d, want 1/1/1", obs_x.size(), oCount, ndone); end
        checks++;
        if (oBestX !== 13'd8191 || oBestY !== 13'd0 || oBestScore !== 24'd0) begin errors++; $display("FAIL edge_best: got %0d@(%0d,%0d), want 0@(8191,0)", oBestScore, oBestX, oBestY); end
    endtask

    task automatic test_invalid;
        run_sweep(5, 0, 4, 9, 1, 0, 0);
        checks++;
        if (done_cyc != 0 || oError !== 1'b1 || oCount !== 16'd0 || obs_x.size() != 0) begin
            errors++; $display("FAIL invalid_x: got done_cyc=%0d err=%0b cnt=%0d starts=%0d, want 0/1/0/0", done_cyc, oError, oCount, obs_x.size());
        end
        run_sweep(0, 3, 2, 2, 1, 0, 0);
        checks++;
        if (done_cyc != 0 || oError !== 1'b1 || obs_x.size() != 0 || busy_after != 0) begin
            errors++; $display("FAIL invalid_y: got done_cyc=%0d err=%0b starts=%0d busy=%0d, want 0/1/0/0", done_cyc, oError, obs_x.size(), busy_after);
        end
    endtask

    task automatic test_timeout;
        logic [23:0] bs;
        logic [15:0] bc;
        run_sweep(1, 1, 4, 1, 1, 2, 0);
        checks++;
        if (oError !== 1'b1 || oCount !== 16'd1 || ndone != 1) begin errors++; $display("FAIL timeout_result: got err=%0b cnt=%0d done=%0d, want 1/1/1", oError, oCount, ndone); end
        checks++;
        if (st_cyc.size() != 2 || done_cyc != st_cyc[1] + 17) begin errors++; $display("FAIL timeout_timing: got done cyc %0d, want second start + 17", done_cyc); end
        checks++;
        if (oBestScore !== 24'(used[0]) || oBestX !== 13'd1) begin errors++; $display("FAIL timeout_best: got %0d@%0d, want %0d@1", oBestScore, oBestX, used[0]); end
        bs = oBestScore;
        bc = oCount;
        iCorrDone = 1'b1;
        iCorrScore = 24'hFFFFFF;
        tick;
        iCorrDone = 1'b0;
        tick; tick;
        checks++;
        if (oBestScore !== bs || oCount !== bc || oBusy !== 1'b0 || oError !== 1'b1) begin
            errors++; $display("FAIL late_done_ignored: got best=%0d cnt=%0d busy=%0b, want %0d/%0d/0", oBestScore, oCount, oBusy, bs, bc);
        end
    endtask

    task automatic test_random;
        int x0, y0, st, bi;
        for (int n = 0; n < 8; n++) begin
            st = $urandom_range(0, 4);
            x0 = $urandom_range(0, 8180);
            y0 = $urandom_range(0, 8180);
            run_sweep(x0, y0, x0 + $urandom_range(0, 8), y0 + $urandom_range(0, 6), st, 0, 0);
            model_positions(x0, y0, int'(iXmax), int'(iYmax), st);
            bi = best_idx();
            checks++;
            if (!pos_match() || oCount !== 16'(exp_x.size()) || !timing_ok()) begin
                errors++; $display("FAIL random_sweep%0d: got %0d starts cnt %0d, want %0d", n, obs_x.size(), oCount, exp_x.size());
            end
            checks++;
            if (oBestScore !== 24'(used[bi]) || oBestX !== 13'(exp_x[bi]) || oBestY !== 13'(exp_y[bi]) || oError !== 1'b0) begin
                errors++; $display("FAIL random_best%0d: got %0d@(%0d,%0d), want %0d@(%0d,%0d)", n, oBestScore, oBestX, oBestY, used[bi], exp_x[bi], exp_y[bi]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0, nz = 0, bi;
        iXmin = 13'd0; iYmin = 13'd0; iXmax = 13'd3; iYmax = 13'd3; iStep = 4'd1;
        iStart = 1'b1;
        tick;
        iStart = 1'b0;
        tick; tick;
        iRST = 1'b1;
        tick;
        iRST = 1'b0;
        test_reset;
        for (int c = 0; c < 6; c++) begin
            iCorrDone = c == 1;
            iCorrScore = 24'hABCDEF;
            seen += int'(oCorrStart);
            if ({oBusy, oDone, oError, oBestScore, oCount, oBestX, oBestY} !== '0) nz++;
            tick;
        end
        iCorrDone = 1'b0;
        checks++;
        if (seen != 0 || nz != 0) begin errors++; $display("FAIL reset_quiet: got %0d starts %0d nonzero cycles, want 0/0", seen, nz); end
        run_sweep(2, 3, 4, 4, 1, 0, 1);
        model_positions(2, 3, 4, 4, 1);
        bi = best_idx();
        checks++;
        if (!pos_match() || oCount !== 16'd6 || ndone != 1) begin errors++; $display("FAIL busy_start_ignored: got %0d starts cnt %0d, want 6", obs_x.size(), oCount); end
        checks++;
        if (oBestScore !== 24'(used[bi]) || oBestX !== 13'(exp_x[bi]) || oBestY !== 13'(exp_y[bi])) begin
            errors++; $display("FAIL busy_start_best: got %0d@(%0d,%0d), want %0d", oBestScore, oBestX, oBestY, used[bi]);
        end
    endtask

    initial begin
        tick; tick; tick;
        iRST = 1'b0;
        test_reset;
        test_basic_window;
        test_step;
        test_edge_coord;
        test_invalid;
        test_timeout;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
